accumulator_reg: RTL and testbench



---
 rtl/accumulator_reg.sv | 34 +++
 tb/tb_accumulator_reg.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/accumulator_reg.sv
// Accumulator register: loads i_mux on enabled rising edges, one-edge latency, no combinational input->output path.
// No backpressure: enable is a plain load strobe; synchronous active-high reset takes priority over enable.
module accumulator_reg #(
  parameter int E_BITS = 16
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              enable,
  input  logic [E_BITS-1:0] i_mux,
  output logic [E_BITS-1:0] o_acc
);

  logic [E_BITS-1:0] acc_d;
  logic [E_BITS-1:0] acc_q;

  always_comb begin
    acc_d = acc_q;
    if (enable) begin
      acc_d = i_mux;
    end
  end

  // Reset is applied here so it overrides any load on the same edge.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign o_acc = acc_q;

endmodule

// File: tb/tb_accumulator_reg.sv
// Self-checking bench for accumulator_reg: directed scenarios plus a randomized run against a reference model.
module tb_accumulator_reg;

  localparam int E_BITS = 16;

  logic              i_clock;
  logic              i_reset;
  logic              enable;
  logic [E_BITS-1:0] i_mux;
  logic [E_BITS-1:0] o_acc;

  int checks;
  int failures;

  // Reference: the word most recently loaded since the last reset.
  logic [E_BITS-1:0] model_acc;

  accumulator_reg #(.E_BITS(E_BITS)) dut (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .enable  (enable),
    .i_mux   (i_mux),
    .o_acc   (o_acc)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic tick();
    @(posedge i_clock);
    if (i_reset) model_acc = '0;
    else if (enable) model_acc = i_mux;
    #1;
  endtask

  task automatic test_reset();
    i_reset = 1'b1; enable = 1'b0; i_mux = 16'h0005;
    tick();
    checks++;
    if (o_acc !== 16'h0000) begin
      failures++;
      $display("FAIL reset_first_edge got=%h expected=%h", o_acc, 16'h0000);
    end
    tick();
    checks++;
    if (o_acc !== 16'h0000) begin
      failures++;
      $display("FAIL reset_held got=%h expected=%h", o_acc, 16'h0000);
    end
  endtask

  task automatic test_load_hold();
    i_reset = 1'b0; enable = 1'b1; i_mux = 16'h0005;
    tick();
    checks++;
    if (o_acc !== 16'h0005) begin
      failures++;
      $display("FAIL load_5 got=%h expected=%h", o_acc, 16'h0005);
    end
    enable = 1'b0;
    tick();
    checks++;
    if (o_acc !== 16'h0005) begin
      failures++;
      $display("FAIL hold_5 got=%h expected=%h", o_acc, 16'h0005);
    end
  endtask

  task automatic test_ignore_mux();
    enable = 1'b0; i_mux = 16'h000E;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (o_acc !== 16'h0005) begin
        failures++;
        $display("FAIL ignore_mux_%0d got=%h expected=%h", i, o_acc, 16'h0005);
      end
    end
    enable = 1'b1;
    tick();
    checks++;
    if (o_acc !== 16'h000E) begin
      failures++;
      $display("FAIL load_E got=%h expected=%h", o_acc, 16'h000E);
    end
    enable = 1'b0;
  endtask

  task automatic test_reset_priority();
    i_reset = 1'b1; enable = 1'b1; i_mux = 16'hFFFF;
    tick();
    checks++;
    if (o_acc !== 16'h0000) begin
      failures++;
      $display("FAIL reset_wins got=%h expected=%h", o_acc, 16'h0000);
    end
    i_reset = 1'b0;
    tick();
    checks++;
    if (o_acc !== 16'hFFFF) begin
      failures++;
      $display("FAIL load_after_reset got=%h expected=%h", o_acc, 16'hFFFF);
    end
  endtask

  task automatic test_back_to_back();
    logic [E_BITS-1:0] exp_vals [3];
    exp_vals[0] = 16'h0001; exp_vals[1] = 16'h0002; exp_vals[2] = 16'h0003;
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_mux = exp_vals[i];
      tick();
      checks++;
      if (o_acc !== exp_vals[i]) begin
        failures++;
        $display("FAIL back_to_back_%0d got=%h expected=%h", i, o_acc, exp_vals[i]);
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_glitch();
    // Inputs wiggle between edges but are quiescent at the edge.
    enable = 1'b0; i_mux = 16'h1234;
    #1 enable = 1'b1; i_mux = 16'hA5A5;
    #1;
    checks++;
    if (o_acc !== 16'h0003) begin
      failures++;
      $display("FAIL no_comb_path got=%h expected=%h", o_acc, 16'h0003);
    end
    #1 i_mux = 16'h5A5A;
    #1 enable = 1'b0;
    tick();
    checks++;
    if (o_acc !== 16'h0003) begin
      failures++;
      $display("FAIL glitch_ignored got=%h expected=%h", o_acc, 16'h0003);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      i_reset = ($urandom_range(0, 19) == 0);
      enable  = $urandom_range(0, 1) == 1;
      i_mux   = E_BITS'($urandom);
      tick();
      checks++;
      if (o_acc !== model_acc) begin
        failures++;
        $display("FAIL random_%0d got=%h expected=%h", i, o_acc, model_acc);
      end
    end
    i_reset = 1'b0;
    enable  = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    model_acc = '0;
    i_reset = 1'b1;
    enable = 1'b0;
    i_mux = '0;
    #1;
    test_reset();
    test_load_hold();
    test_ignore_mux();
    test_reset_priority();
    test_back_to_back();
    test_glitch();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
